// File: rtl/gelato_register_bank_arbiter.sv
// Banked register-file read arbiter: one collect request per 3 cycles, one read per bank per round.
// Optional conflict statistics are enabled with `define GELATO_BANK_CONFLICT_STAT_EN.
module gelato_register_bank_arbiter #(
  parameter int COLLECTOR_SIZE = 4,
  parameter int BANK_NUM       = 4,
  parameter int REG_W          = 5,
  parameter int DATA_W         = 32,
  parameter int CIDX_W         = $clog2(COLLECTOR_SIZE),
  parameter int BANK_W         = $clog2(BANK_NUM),
  parameter int NSLOT          = COLLECTOR_SIZE * 3,
  parameter int ROW_W          = REG_W - BANK_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rdy,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [COLLECTOR_SIZE-1:0]    req_entry_valid,
  input  logic [COLLECTOR_SIZE*CIDX_W-1:0] req_collector_num,
  input  logic [NSLOT*REG_W-1:0]       req_reg_num,
  input  logic [NSLOT-1:0]             req_reg_valid,
  output logic [BANK_NUM-1:0]          bank_rd_en,
  output logic [BANK_NUM*ROW_W-1:0]    bank_rd_addr,
  input  logic [BANK_NUM*DATA_W-1:0]   bank_rd_data,
  output logic                         resp_valid,
  output logic [BANK_NUM-1:0]          resp_data_valid,
  output logic [BANK_NUM*CIDX_W-1:0]   resp_collector_index,
  output logic [BANK_NUM*2-1:0]        resp_reg_index,
  output logic [BANK_NUM*DATA_W-1:0]   resp_data
`ifdef GELATO_BANK_CONFLICT_STAT_EN
  ,
  output logic [31:0]                  conflict_cnt,
  output logic                         conflict_any
`endif
);

  localparam int SLOT_W = $clog2(NSLOT);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]                  state_r;
  logic [SLOT_W-1:0]           ptr_r [BANK_NUM];
  logic                        req_ready_r;
  logic [BANK_NUM-1:0]         bank_rd_en_r;
  logic [BANK_NUM*ROW_W-1:0]   bank_rd_addr_r;
  logic [BANK_NUM-1:0]         gnt_valid_r;
  logic [BANK_NUM*CIDX_W-1:0]  gnt_cidx_r;
  logic [BANK_NUM*2-1:0]       gnt_op_r;
  logic                        resp_valid_r;
  logic [BANK_NUM-1:0]         resp_data_valid_r;
  logic [BANK_NUM*CIDX_W-1:0]  resp_collector_index_r;
  logic [BANK_NUM*2-1:0]       resp_reg_index_r;
  logic [BANK_NUM*DATA_W-1:0]  data_hold_r;

  logic [NSLOT-1:0]            pending_s;
  logic [BANK_NUM-1:0]         gnt_hit_s;
  logic [SLOT_W-1:0]           gnt_slot_s [BANK_NUM];
  logic [ROW_W-1:0]            gnt_row_s [BANK_NUM];
  logic [CIDX_W-1:0]           gnt_cidx_s [BANK_NUM];
  logic [1:0]                  gnt_op_s [BANK_NUM];
  logic [SLOT_W-1:0]           next_ptr_s [BANK_NUM];
  logic [BANK_NUM*DATA_W-1:0]  lane_data_s;

`ifdef GELATO_BANK_CONFLICT_STAT_EN
  logic [31:0] conflict_cnt_r;
  logic        conflict_any_r;
  logic        conflict_flag_r;
  logic [32:0] conflict_sum_s;
  logic [31:0] lost_s;
`endif

  // Arbitration is evaluated on the incoming request so the bank strobe is registered for READ.
  always_comb begin
    int idx;
    int slot_i;
    logic take;
    idx = 0;
    slot_i = 0;
    take = 1'b0;
    pending_s = '0;
    for (int s = 0; s < NSLOT; s++) begin
      pending_s[s] = req_reg_valid[s] & req_entry_valid[s / 3];
    end
    for (int b = 0; b < BANK_NUM; b++) begin
      gnt_hit_s[b]  = 1'b0;
      gnt_slot_s[b] = '0;
      for (int k = 0; k < NSLOT; k++) begin
        idx  = int'(ptr_r[b]) + k;
        idx  = (idx >= NSLOT) ? idx - NSLOT : idx;
        take = !gnt_hit_s[b] && pending_s[idx] &&
               (req_reg_num[idx*REG_W +: BANK_W] == BANK_W'(b));
        gnt_slot_s[b] = take ? SLOT_W'(idx) : gnt_slot_s[b];
        gnt_hit_s[b]  = gnt_hit_s[b] | take;
      end
      slot_i        = int'(gnt_slot_s[b]);
      gnt_row_s[b]  = req_reg_num[slot_i*REG_W + BANK_W +: ROW_W];
      gnt_cidx_s[b] = req_collector_num[(slot_i / 3)*CIDX_W +: CIDX_W];
      gnt_op_s[b]   = 2'(slot_i % 3 + 1);
      next_ptr_s[b] = (slot_i == NSLOT - 1) ? '0 : SLOT_W'(slot_i + 1);
    end
  end

`ifdef GELATO_BANK_CONFLICT_STAT_EN
  // Losers of this round, accumulated with saturation.
  always_comb begin
    lost_s         = 32'($countones(pending_s)) - 32'($countones(gnt_hit_s));
    conflict_sum_s = {1'b0, conflict_cnt_r} + {1'b0, lost_s};
  end
`endif

  // Response lanes pass read data through during RESP and hold it afterwards.
  always_comb begin
    lane_data_s = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      lane_data_s[b*DATA_W +: DATA_W] = resp_data_valid_r[b] ? bank_rd_data[b*DATA_W +: DATA_W]
                                                               : {DATA_W{1'b0}};
    end
  end

  // Control FSM, round-robin pointers and registered outputs; rdy=0 freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r                <= IDLE;
      req_ready_r            <= 1'b1;
      bank_rd_en_r           <= '0;
      bank_rd_addr_r         <= '0;
      gnt_valid_r            <= '0;
      gnt_cidx_r             <= '0;
      gnt_op_r               <= '0;
      resp_valid_r           <= 1'b0;
      resp_data_valid_r      <= '0;
      resp_collector_index_r <= '0;
      resp_reg_index_r       <= '0;
      data_hold_r            <= '0;
      for (int b = 0; b < BANK_NUM; b++) begin
        ptr_r[b] <= '0;
      end
`ifdef GELATO_BANK_CONFLICT_STAT_EN
      conflict_cnt_r  <= 32'd0;
      conflict_any_r  <= 1'b0;
      conflict_flag_r <= 1'b0;
`endif
    end else if (rdy) begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            state_r     <= READ;
            req_ready_r <= 1'b0;
            for (int b = 0; b < BANK_NUM; b++) begin
              bank_rd_en_r[b]                   <= gnt_hit_s[b];
              bank_rd_addr_r[b*ROW_W +: ROW_W]  <= gnt_hit_s[b] ? gnt_row_s[b] : {ROW_W{1'b0}};
              gnt_valid_r[b]                    <= gnt_hit_s[b];
              gnt_cidx_r[b*CIDX_W +: CIDX_W]    <= gnt_hit_s[b] ? gnt_cidx_s[b] : {CIDX_W{1'b0}};
              gnt_op_r[b*2 +: 2]                <= gnt_hit_s[b] ? gnt_op_s[b] : 2'd0;
              if (gnt_hit_s[b]) begin
                ptr_r[b] <= next_ptr_s[b];
              end
            end
`ifdef GELATO_BANK_CONFLICT_STAT_EN
            conflict_cnt_r  <= conflict_sum_s[32] ? 32'hFFFF_FFFF : conflict_sum_s[31:0];
            conflict_flag_r <= (lost_s != 32'd0);
`endif
          end
        end
        READ: begin
          state_r                <= RESP;
          bank_rd_en_r           <= '0;
          resp_valid_r           <= 1'b1;
          resp_data_valid_r      <= gnt_valid_r;
          resp_collector_index_r <= gnt_cidx_r;
          resp_reg_index_r       <= gnt_op_r;
`ifdef GELATO_BANK_CONFLICT_STAT_EN
          conflict_any_r <= conflict_flag_r;
`endif
        end
        RESP: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          data_hold_r  <= lane_data_s;
`ifdef GELATO_BANK_CONFLICT_STAT_EN
          conflict_any_r <= 1'b0;
`endif
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          bank_rd_en_r <= '0;
          resp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready            = req_ready_r;
  assign bank_rd_en           = bank_rd_en_r;
  assign bank_rd_addr         = bank_rd_addr_r;
  assign resp_valid           = resp_valid_r;
  assign resp_data_valid      = resp_data_valid_r;
  assign resp_collector_index = resp_collector_index_r;
  assign resp_reg_index       = resp_reg_index_r;
  assign resp_data            = (state_r == RESP) ? lane_data_s : data_hold_r;
`ifdef GELATO_BANK_CONFLICT_STAT_EN
  assign conflict_cnt = conflict_cnt_r;
  assign conflict_any = conflict_any_r;
`endif

endmodule

// File: tb/tb_gelato_register_bank_arbiter.sv
// Randomized bench for gelato_register_bank_arbiter against a slot-list round-robin reference model.
module tb_gelato_register_bank_arbiter;
  localparam int NS = 12;

  logic          clk = 1'b0;
  logic          rst_n, rdy, req_valid, req_ready;
  logic [3:0]    req_entry_valid;
  logic [7:0]    req_collector_num;
  logic [59:0]   req_reg_num;
  logic [11:0]   req_reg_valid;
  logic [3:0]    bank_rd_en;
  logic [11:0]   bank_rd_addr;
  logic [127:0]  bank_rd_data = '0;
  logic          resp_valid;
  logic [3:0]    resp_data_valid;
  logic [7:0]    resp_collector_index;
  logic [7:0]    resp_reg_index;
  logic [127:0]  resp_data;
`ifdef GELATO_BANK_CONFLICT_STAT_EN
  logic [31:0]   conflict_cnt;
  logic          conflict_any;
  logic [31:0]   ref_cnt = 32'd0;
`endif

  gelato_register_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .req_valid(req_valid), .req_ready(req_ready),
    .req_entry_valid(req_entry_valid), .req_collector_num(req_collector_num),
    .req_reg_num(req_reg_num), .req_reg_valid(req_reg_valid),
    .bank_rd_en(bank_rd_en), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
    .resp_valid(resp_valid), .resp_data_valid(resp_data_valid),
    .resp_collector_index(resp_collector_index), .resp_reg_index(resp_reg_index),
    .resp_data(resp_data)
`ifdef GELATO_BANK_CONFLICT_STAT_EN
    , .conflict_cnt(conflict_cnt), .conflict_any(conflict_any)
`endif
  );

  always #5 clk = ~clk;

  // Register bank model: synchronous read, data one cycle after the strobe.
  logic [31:0] mem [4][8];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bank_rd_en[b]) bank_rd_data[b*32 +: 32] <= mem[b][bank_rd_addr[b*3 +: 3]];
    end
  end

  int checks = 0;
  int failures = 0;
  int ref_ptr [4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, predict grants from per-bank slot lists, then check READ, RESP and hold.
  task automatic run_req(input logic [3:0] ev, input logic [7:0] cn, input logic [59:0] rn,
                         input logic [11:0] rv, input int stall);
    int q[$];
    int gnt [4];
    bit gv [4];
    int pend, ngr, r;
    logic [3:0] exp_en;
    logic [31:0] exp_data [4];
    pend = 0;
    ngr = 0;
    exp_en = 4'b0000;
    for (int s = 0; s < NS; s++) if (rv[s] && ev[s/3]) pend++;
    for (int b = 0; b < 4; b++) begin
      q.delete();
      for (int s = 0; s < NS; s++)
        if (rv[s] && ev[s/3] && (int'(rn[s*5 +: 5]) % 4) == b) q.push_back(s);
      gv[b] = (q.size() > 0);
      gnt[b] = 0;
      exp_data[b] = 32'd0;
      if (gv[b]) begin
        gnt[b] = q[0];
        for (int i = 0; i < q.size(); i++)
          if (q[i] >= ref_ptr[b]) begin gnt[b] = q[i]; break; end
        ref_ptr[b] = (gnt[b] + 1) % NS;
        exp_en[b] = 1'b1;
        ngr++;
        r = int'(rn[gnt[b]*5 + 2 +: 3]);
        exp_data[b] = mem[b][r];
      end
    end

    req_valid = 1'b1;
    req_entry_valid = ev;
    req_collector_num = cn;
    req_reg_num = rn;
    req_reg_valid = rv;
    check_val("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_val("read_rd_en", {28'd0, bank_rd_en}, {28'd0, exp_en});
    for (int b = 0; b < 4; b++)
      if (gv[b]) check_val("read_addr", {29'd0, bank_rd_addr[b*3 +: 3]}, {29'd0, rn[gnt[b]*5 + 2 +: 3]});
    if (stall > 0) begin
      rdy = 1'b0;
      repeat (stall) begin @(posedge clk); #1; end
      check_val("stall_no_resp", {31'd0, resp_valid}, 32'd0);
      check_val("stall_rd_en", {28'd0, bank_rd_en}, {28'd0, exp_en});
      rdy = 1'b1;
    end
    @(posedge clk); #1;
    check_val("resp_valid", {31'd0, resp_valid}, 32'd1);
    check_val("resp_data_valid", {28'd0, resp_data_valid}, {28'd0, exp_en});
    for (int b = 0; b < 4; b++) begin
      if (gv[b]) begin
        check_val("resp_cidx", {30'd0, resp_collector_index[b*2 +: 2]}, {30'd0, cn[(gnt[b]/3)*2 +: 2]});
        check_val("resp_op", {30'd0, resp_reg_index[b*2 +: 2]}, 32'(gnt[b] % 3 + 1));
        check_val("resp_data", resp_data[b*32 +: 32], exp_data[b]);
      end
    end
`ifdef GELATO_BANK_CONFLICT_STAT_EN
    begin
      logic [32:0] sum;
      sum = {1'b0, ref_cnt} + 33'(pend - ngr);
      ref_cnt = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
      check_val("conflict_cnt", conflict_cnt, ref_cnt);
      check_val("conflict_any", {31'd0, conflict_any}, {31'd0, (pend != ngr)});
    end
`endif
    @(posedge clk); #1;
    check_val("resp_pulse_end", {31'd0, resp_valid}, 32'd0);
    check_val("req_ready_back", {31'd0, req_ready}, 32'd1);
    for (int b = 0; b < 4; b++)
      if (gv[b]) check_val("resp_data_hold", resp_data[b*32 +: 32], exp_data[b]);
  endtask

  initial begin
    logic [59:0] rn;
    int st;
    rst_n = 1'b0;
    rdy = 1'b1;
    req_valid = 1'b0;
    req_entry_valid = 4'd0;
    req_collector_num = 8'd0;
    req_reg_num = 60'd0;
    req_reg_valid = 12'd0;
    for (int b = 0; b < 4; b++) begin
      ref_ptr[b] = 0;
      for (int r = 0; r < 8; r++) mem[b][r] = $urandom;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_val("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check_val("rst_rd_en", {28'd0, bank_rd_en}, 32'd0);
    check_val("rst_data_valid", {28'd0, resp_data_valid}, 32'd0);

    // No conflict: regs 5,6,7 on banks 1..3, row 1.
    rn = '0; rn[0 +: 5] = 5'd5; rn[5 +: 5] = 5'd6; rn[10 +: 5] = 5'd7;
    run_req(4'b0001, 8'hE4, rn, 12'b0000_0000_0111, 0);
    check_val("dir_op_lane3", {30'd0, resp_reg_index[7:6]}, 32'd3);

    // Conflict on bank 0, then the loser re-requested alone.
    rn = '0; rn[0 +: 5] = 5'd4; rn[15 +: 5] = 5'd8;
    run_req(4'b0011, 8'hE4, rn, 12'b0000_0000_1001, 0);
    check_val("conflict_winner", {30'd0, resp_collector_index[1:0]}, 32'd0);
    run_req(4'b0011, 8'hE4, rn, 12'b0000_0000_1000, 0);
    check_val("rerequest_winner", {30'd0, resp_collector_index[1:0]}, 32'd1);

    // Round robin: pointer at 4, slots 0 and 6 both on bank 0.
    rn = '0; rn[0 +: 5] = 5'd4; rn[30 +: 5] = 5'd12;
    run_req(4'b0101, 8'hE4, rn, 12'b0000_0100_0001, 0);
    check_val("rr_cidx", {30'd0, resp_collector_index[1:0]}, 32'd2);

    // Empty request, then a 3-cycle stall in READ, then three slots on bank 2.
    run_req(4'b1111, 8'hE4, 60'd0, 12'd0, 0);
    rn = '0; rn[0 +: 5] = 5'd5; rn[5 +: 5] = 5'd6; rn[10 +: 5] = 5'd7;
    run_req(4'b0001, 8'hE4, rn, 12'b0000_0000_0111, 3);
    rn = '0; rn[0 +: 5] = 5'd2; rn[5 +: 5] = 5'd6; rn[10 +: 5] = 5'd10;
    run_req(4'b0001, 8'hE4, rn, 12'b0000_0000_0111, 0);

    for (int i = 0; i < 60; i++) begin
      rn = {$urandom, $urandom};
      st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_req(4'($urandom), 8'($urandom), rn, 12'($urandom), st);
    end

    // Reset during READ drops the request.
    rn = '0; rn[0 +: 5] = 5'd4; rn[15 +: 5] = 5'd8;
    req_valid = 1'b1; req_entry_valid = 4'b0011; req_reg_num = rn; req_reg_valid = 12'b1001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) ref_ptr[b] = 0;
    repeat (3) begin
      check_val("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check_val("midrst_ready", {31'd0, req_ready}, 32'd1);
    check_val("midrst_rd_en", {28'd0, bank_rd_en}, 32'd0);
`ifdef GELATO_BANK_CONFLICT_STAT_EN
    ref_cnt = 32'd0;
    check_val("midrst_cnt", conflict_cnt, 32'd0);
`endif
    run_req(4'b0011, 8'hE4, rn, 12'b0000_0000_1001, 0);
    check_val("post_rst_ptr", {30'd0, resp_collector_index[1:0]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
